// File: rtl/itlb_micro.sv
// Four-entry fully-associative instruction micro-TLB. Hits and kseg0/kseg1 translate in the
// same cycle; a miss stalls fetch while one lookup goes to tlb_trans, then fills or raises an exception.
module itlb_micro #(
  parameter int ENTRIES = 4,
  parameter int PFN_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_en,
  input  logic [31:0]      inst_vaddr,
  input  logic [7:0]       asid,
  input  logic             flushF,
  input  logic             tlb_wr,
  output logic [PFN_W-1:0] inst_pfn,
  output logic             no_cache_i,
  output logic             hit,
  output logic             stall_req,
  output logic             inst_tlb_refill,
  output logic             inst_tlb_invalid,
  output logic             req_valid,
  output logic [19:0]      req_vpn,
  input  logic             resp_valid,
  input  logic [PFN_W-1:0] resp_pfn,
  input  logic             resp_uncached,
  input  logic             resp_global,
  input  logic             resp_refill,
  input  logic             resp_invalid
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_EXC,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   g_q, g_d;
  logic [ENTRIES-1:0]   unc_q, unc_d;
  logic [19:0]          vpn_q  [ENTRIES];
  logic [19:0]          vpn_d  [ENTRIES];
  logic [7:0]           easid_q [ENTRIES];
  logic [7:0]           easid_d [ENTRIES];
  logic [PFN_W-1:0]     pfn_q  [ENTRIES];
  logic [PFN_W-1:0]     pfn_d  [ENTRIES];
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  // Miss context: address/ASID captured at the miss, response captured in WAIT
  logic [19:0]          mvpn_q, mvpn_d;
  logic [7:0]           masid_q, masid_d;
  logic [PFN_W-1:0]     rpfn_q, rpfn_d;
  logic                 runc_q, runc_d;
  logic                 rg_q, rg_d;
  logic                 rrefill_q, rrefill_d;
  logic                 rinvalid_q, rinvalid_d;

  logic                 unmapped;
  logic                 match;
  logic [PFN_W-1:0]     match_pfn;
  logic                 match_unc;
  logic                 unused_vaddr_lo;

  assign unmapped        = (inst_vaddr[31:30] == 2'b10);
  assign unused_vaddr_lo = ^inst_vaddr[11:0];

  // At most one entry matches, so OR-combining the hit data is exact
  always_comb begin
    match     = 1'b0;
    match_pfn = '0;
    match_unc = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == inst_vaddr[31:12]) &&
          (g_q[i] || (easid_q[i] == asid))) begin
        match     = 1'b1;
        match_pfn = match_pfn | pfn_q[i];
        match_unc = match_unc | unc_q[i];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    g_d              = g_q;
    unc_d            = unc_q;
    vpn_d            = vpn_q;
    easid_d          = easid_q;
    pfn_d            = pfn_q;
    ptr_d            = ptr_q;
    mvpn_d           = mvpn_q;
    masid_d          = masid_q;
    rpfn_d           = rpfn_q;
    runc_d           = runc_q;
    rg_d             = rg_q;
    rrefill_d        = rrefill_q;
    rinvalid_d       = rinvalid_q;
    inst_pfn         = '0;
    no_cache_i       = 1'b0;
    hit              = 1'b0;
    stall_req        = 1'b0;
    inst_tlb_refill  = 1'b0;
    inst_tlb_invalid = 1'b0;
    req_valid        = 1'b0;
    req_vpn          = '0;

    if (inst_en && unmapped) begin
      hit        = 1'b1;
      inst_pfn   = PFN_W'(inst_vaddr[28:12]);
      no_cache_i = inst_vaddr[29];
    end else if (inst_en && (state_q == S_IDLE) && match) begin
      hit        = 1'b1;
      inst_pfn   = match_pfn;
      no_cache_i = match_unc;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_en && !unmapped && !match) begin
          stall_req = 1'b1;
          mvpn_d    = inst_vaddr[31:12];
          masid_d   = asid;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        stall_req = 1'b1;
        if (flushF) begin
          state_d = S_IDLE;
        end else begin
          req_valid = 1'b1;
          req_vpn   = mvpn_q;
          // A TLB write while the lookup is in flight makes its answer stale
          state_d   = tlb_wr ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (resp_valid) begin
          rpfn_d     = resp_pfn;
          runc_d     = resp_uncached;
          rg_d       = resp_global;
          rrefill_d  = resp_refill;
          rinvalid_d = resp_invalid;
          if (flushF || tlb_wr)
            state_d = S_IDLE;
          else if (resp_refill || resp_invalid)
            state_d = S_EXC;
          else
            state_d = S_FILL;
        end else if (flushF || tlb_wr) begin
          state_d = S_DRAIN;
        end
      end
      S_FILL: begin
        stall_req = 1'b1;
        if (!tlb_wr) begin
          for (int i = 0; i < ENTRIES; i++) begin
            if (ptr_q == PTR_W'(i)) begin
              valid_d[i] = 1'b1;
              vpn_d[i]   = mvpn_q;
              easid_d[i] = masid_q;
              g_d[i]     = rg_q;
              pfn_d[i]   = rpfn_q;
              unc_d[i]   = runc_q;
            end
          end
          ptr_d = ptr_q + PTR_W'(1);
        end
        state_d = S_IDLE;
      end
      S_EXC: begin
        inst_tlb_refill  = rrefill_q & ~flushF;
        inst_tlb_invalid = rinvalid_q & ~flushF;
        state_d          = S_IDLE;
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        if (resp_valid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tlb_wr)
      valid_d = '0;

    if (rst) begin
      inst_pfn         = '0;
      no_cache_i       = 1'b0;
      hit              = 1'b0;
      stall_req        = 1'b0;
      inst_tlb_refill  = 1'b0;
      inst_tlb_invalid = 1'b0;
      req_valid        = 1'b0;
      req_vpn          = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    g_q        <= g_d;
    unc_q      <= unc_d;
    vpn_q      <= vpn_d;
    easid_q    <= easid_d;
    pfn_q      <= pfn_d;
    mvpn_q     <= mvpn_d;
    masid_q    <= masid_d;
    rpfn_q     <= rpfn_d;
    runc_q     <= runc_d;
    rg_q       <= rg_d;
    rrefill_q  <= rrefill_d;
    rinvalid_q <= rinvalid_d;
  end

endmodule

// File: tb/tb_itlb_micro.sv
// Bench for itlb_micro: directed scenarios plus randomized fetches, checked cycle by cycle
// against a table-based micro-TLB model with a modulo round-robin fill pointer.
module tb_itlb_micro;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_vaddr;
  logic [7:0]  asid;
  logic        flushF;
  logic        tlb_wr;
  logic [19:0] inst_pfn;
  logic        no_cache_i;
  logic        hit;
  logic        stall_req;
  logic        inst_tlb_refill;
  logic        inst_tlb_invalid;
  logic        req_valid;
  logic [19:0] req_vpn;
  logic        resp_valid;
  logic [19:0] resp_pfn;
  logic        resp_uncached;
  logic        resp_global;
  logic        resp_refill;
  logic        resp_invalid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain table of entries, victim index advanced modulo 4
  bit          m_valid [4];
  logic [19:0] m_vpn   [4];
  logic [7:0]  m_asid  [4];
  bit          m_g     [4];
  logic [19:0] m_pfn   [4];
  bit          m_unc   [4];
  int          m_ptr;

  itlb_micro #(.ENTRIES(4), .PFN_W(20)) dut (
    .clk(clk), .rst(rst), .inst_en(inst_en), .inst_vaddr(inst_vaddr), .asid(asid),
    .flushF(flushF), .tlb_wr(tlb_wr), .inst_pfn(inst_pfn), .no_cache_i(no_cache_i),
    .hit(hit), .stall_req(stall_req), .inst_tlb_refill(inst_tlb_refill),
    .inst_tlb_invalid(inst_tlb_invalid), .req_valid(req_valid), .req_vpn(req_vpn),
    .resp_valid(resp_valid), .resp_pfn(resp_pfn), .resp_uncached(resp_uncached),
    .resp_global(resp_global), .resp_refill(resp_refill), .resp_invalid(resp_invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [19:0] vpn, input logic [7:0] as,
                                   output logic [19:0] p, output bit u);
    p = '0;
    u = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn && (m_g[i] || m_asid[i] == as)) begin
        p = m_pfn[i];
        u = m_unc[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    inst_en = 0; inst_vaddr = '0; asid = '0; flushF = 0; tlb_wr = 0;
    resp_valid = 0; resp_pfn = '0; resp_uncached = 0; resp_global = 0;
    resp_refill = 0; resp_invalid = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    inst_en = 1; inst_vaddr = 32'hBFC0_0000;
    step();
    step();
    chk_eq("rst_hit", 32'(hit), 32'd0);
    chk_eq("rst_stall", 32'(stall_req), 32'd0);
    chk_eq("rst_req", 32'(req_valid), 32'd0);
    chk_eq("rst_pfn", 32'(inst_pfn), 32'd0);
    chk_eq("rst_exc", 32'({inst_tlb_refill, inst_tlb_invalid, no_cache_i}), 32'd0);
    rst = 0;
    idle_inputs();
    model_clear();
    m_ptr = 0;
  endtask

  // One fetch; services a miss with a response k cycles after REQ (k >= 1)
  task automatic access(input logic [31:0] va, input logic [7:0] as, input int k,
                        input logic [19:0] rp, input bit ru, input bit rg,
                        input bit rf, input bit rinv, input bit wr_at_fill);
    logic [19:0] ep;
    bit          eu;
    int          stalls;
    inst_en = 1; inst_vaddr = va; asid = as;
    #1;
    if (va[31:30] == 2'b10) begin
      chk_eq("um_hit", 32'(hit), 32'd1);
      chk_eq("um_pfn", 32'(inst_pfn), 32'(va[28:12]));
      chk_eq("um_nc", 32'(no_cache_i), 32'(va[29]));
      chk_eq("um_stall", 32'(stall_req), 32'd0);
      step();
      inst_en = 0;
      return;
    end
    if (model_hit(va[31:12], as, ep, eu)) begin
      chk_eq("hit", 32'(hit), 32'd1);
      chk_eq("hit_pfn", 32'(inst_pfn), 32'(ep));
      chk_eq("hit_nc", 32'(no_cache_i), 32'(eu));
      chk_eq("hit_stall", 32'(stall_req), 32'd0);
      step();
      inst_en = 0;
      return;
    end
    chk_eq("miss_hit", 32'(hit), 32'd0);
    chk_eq("miss_req", 32'(req_valid), 32'd0);
    stalls = 32'(stall_req);
    step();
    chk_eq("req_valid", 32'(req_valid), 32'd1);
    chk_eq("req_vpn", 32'(req_vpn), 32'(va[31:12]));
    stalls += 32'(stall_req);
    step();
    for (int i = 1; i <= k; i++) begin
      if (i == k) begin
        resp_valid = 1; resp_pfn = rp; resp_uncached = ru; resp_global = rg;
        resp_refill = rf; resp_invalid = rinv;
      end
      #1;
      chk_eq("wait_req", 32'(req_valid), 32'd0);
      stalls += 32'(stall_req);
      step();
    end
    resp_valid = 0; resp_refill = 0; resp_invalid = 0;
    if (rf || rinv) begin
      chk_eq("exc_refill", 32'(inst_tlb_refill), 32'(rf));
      chk_eq("exc_invalid", 32'(inst_tlb_invalid), 32'(rinv));
      chk_eq("exc_stall", 32'(stall_req), 32'd0);
      chk_eq("exc_hit", 32'(hit), 32'd0);
      chk_eq("exc_stall_cycles", 32'(stalls), 32'(2 + k));
      step();
      inst_en = 0;
      return;
    end
    tlb_wr = wr_at_fill;
    #1;
    stalls += 32'(stall_req);
    chk_eq("fill_hit", 32'(hit), 32'd0);
    step();
    tlb_wr = 0;
    if (wr_at_fill) begin
      model_clear();
    end else begin
      m_valid[m_ptr] = 1; m_vpn[m_ptr] = va[31:12]; m_asid[m_ptr] = as;
      m_g[m_ptr] = rg; m_pfn[m_ptr] = rp; m_unc[m_ptr] = ru;
      m_ptr = (m_ptr + 1) % 4;
    end
    chk_eq("stall_cycles", 32'(stalls), 32'(3 + k));
    if (!wr_at_fill) begin
      chk_eq("post_fill_hit", 32'(hit), 32'd1);
      chk_eq("post_fill_pfn", 32'(inst_pfn), 32'(rp));
      chk_eq("post_fill_nc", 32'(no_cache_i), 32'(ru));
      chk_eq("post_fill_stall", 32'(stall_req), 32'd0);
      step();
    end
    inst_en = 0;
  endtask

  task automatic flush_in_wait(input logic [31:0] va, input logic [7:0] as);
    inst_en = 1; inst_vaddr = va; asid = as;
    #1;
    chk_eq("fl_miss_stall", 32'(stall_req), 32'd1);
    step();
    chk_eq("fl_req", 32'(req_valid), 32'd1);
    step();
    flushF = 1; inst_en = 0;
    #1;
    chk_eq("fl_wait_stall", 32'(stall_req), 32'd1);
    step();
    flushF = 0;
    chk_eq("fl_drain_stall", 32'(stall_req), 32'd1);
    chk_eq("fl_drain_req", 32'(req_valid), 32'd0);
    step();
    resp_valid = 1; resp_pfn = 20'h0DEAD;
    #1;
    chk_eq("fl_resp_stall", 32'(stall_req), 32'd1);
    step();
    resp_valid = 0;
    chk_eq("fl_idle_stall", 32'(stall_req), 32'd0);
    chk_eq("fl_idle_req", 32'(req_valid), 32'd0);
    step();
  endtask

  task automatic reset_mid_miss(input logic [31:0] va);
    inst_en = 1; inst_vaddr = va; asid = 8'd1;
    step();
    chk_eq("rm_req", 32'(req_valid), 32'd1);
    step();
    rst = 1; inst_en = 0;
    #1;
    chk_eq("rm_rst_stall", 32'(stall_req), 32'd0);
    step();
    rst = 0;
    chk_eq("rm_after_stall", 32'(stall_req), 32'd0);
    chk_eq("rm_after_req", 32'(req_valid), 32'd0);
    resp_valid = 1; resp_pfn = 20'h0BEEF;
    step();
    resp_valid = 0;
    chk_eq("rm_stray_stall", 32'(stall_req), 32'd0);
    model_clear();
    m_ptr = 0;
  endtask

  function automatic logic [19:0] pool_vpn(input int i);
    return 20'h10000 + 20'(i);
  endfunction

  initial begin
    logic [19:0] v;
    logic [31:0] va;
    bit          rf, rinv;
    reset_dut();

    access(32'hBFC0_0000, 8'd0, 1, '0, 0, 0, 0, 0, 0);
    access(32'h9FC0_1234, 8'd0, 1, '0, 0, 0, 0, 0, 0);
    access(32'h0040_0000, 8'd1, 2, 20'h12345, 0, 0, 0, 0, 0);
    access(32'h0040_0000, 8'd1, 2, 20'h12345, 0, 0, 0, 0, 0);

    reset_dut();
    for (int i = 1; i <= 5; i++)
      access({12'h004, 8'(i), 12'h000}, 8'd1, 1, 20'h20000 + 20'(i), 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++)
      access({12'h004, 8'(i), 12'h010}, 8'd1, 1, 20'h20000 + 20'(i), 0, 0, 0, 0, 0);
    access(32'h0040_1000, 8'd1, 3, 20'h20001, 1, 0, 0, 0, 0);

    access(32'h0050_0000, 8'd1, 1, '0, 0, 0, 1, 0, 0);
    access(32'h0050_0000, 8'd1, 2, '0, 0, 0, 0, 1, 0);
    access(32'h0050_0000, 8'd1, 1, 20'h05000, 1, 0, 0, 0, 0);

    flush_in_wait(32'h0060_0000, 8'd1);
    access(32'h0060_0000, 8'd1, 1, '0, 0, 0, 1, 0, 0);
    access(32'h0061_0000, 8'd1, 1, 20'h06100, 0, 0, 0, 0, 1);
    access(32'h0040_3000, 8'd1, 1, 20'h20003, 0, 0, 0, 0, 0);

    access(32'h0070_0000, 8'd5, 1, 20'h0AAAA, 0, 0, 0, 0, 0);
    access(32'h0070_0000, 8'd6, 1, 20'h0BBBB, 1, 0, 0, 0, 0);
    access(32'h0070_0000, 8'd5, 1, 20'h0AAAA, 0, 0, 0, 0, 0);
    access(32'h0070_1000, 8'd5, 2, 20'h0CCCC, 0, 1, 0, 0, 0);
    access(32'h0070_1000, 8'h33, 1, 20'h0CCCC, 0, 1, 0, 0, 0);
    access(32'h0070_1000, 8'd6, 1, 20'h0CCCC, 0, 1, 0, 0, 0);

    reset_mid_miss(32'h0080_0000);
    access(32'h0070_1000, 8'd5, 1, 20'h0CCCC, 0, 1, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        va = {2'b10, 1'($urandom), 29'($urandom)};
      end else begin
        v  = pool_vpn(int'($urandom_range(0, 5)));
        va = {v, 12'($urandom)};
      end
      v    = va[31:12];
      rf   = ($urandom_range(0, 7) == 0);
      rinv = !rf && ($urandom_range(0, 7) == 0);
      access(va, 8'(1 + $urandom_range(0, 1)), 1 + int'($urandom_range(0, 2)),
             v ^ 20'hA5A5A, v[1], v[0], rf, rinv, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
